// File: rtl/counter_checker_pkg.sv
// Shared types and default sizes for the counter output checker.
//   state_e  - run-control FSM states
//   DefWidth - default number of compared output bits
//   DefErrW  - default error-counter width
//   DefCycW  - default cycle-index width
package counter_checker_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSkip  = 2'd1,
    StCheck = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefErrW  = 16;
  localparam int unsigned DefCycW  = 16;

endpackage

// File: rtl/checker_popcount.sv
// Combinational population count.
//   vec_i   [WIDTH]           - input vector
//   count_o [clog2(WIDTH+1)]  - number of set bits in vec_i
module checker_popcount #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CntW  = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [CntW-1:0]  count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count_o = count_o + CntW'(vec_i[i]);
    end
  end

endmodule

// File: rtl/counter_output_checker.sv
// Compares fabric outputs against a reference model over a fixed window.
// A start pulse launches a run: SKIP_CYCLES ignored cycles, then RUN_CYCLES
// compare cycles, then DONE with a pass/fail verdict.
//   clk_counter     - clock, rising edge
//   rst_counter     - asynchronous active-high reset
//   start           - single-cycle run launch (ignored while busy)
//   gfpga_q         - fabric outputs under test
//   bench_q         - reference outputs
//   bench_known     - per-bit compare enable (0 = reference unknown)
//   busy            - run in progress (SKIP or CHECK)
//   done            - run finished
//   pass            - in DONE, no errors were counted
//   mismatch_flag   - registered per-bit mismatch of the last CHECK cycle
//   err_count       - saturating count of mismatch rising edges
//   first_err_cycle - CHECK-cycle index of the first error, all-ones if none
module counter_output_checker
  import counter_checker_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned SKIP_CYCLES = 1,
  parameter int unsigned RUN_CYCLES  = 10,
  parameter int unsigned ERR_W       = DefErrW,
  parameter int unsigned CYC_W       = DefCycW
) (
  input  logic             clk_counter,
  input  logic             rst_counter,
  input  logic             start,
  input  logic [WIDTH-1:0] gfpga_q,
  input  logic [WIDTH-1:0] bench_q,
  input  logic [WIDTH-1:0] bench_known,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] mismatch_flag,
  output logic [ERR_W-1:0] err_count,
  output logic [CYC_W-1:0] first_err_cycle
);

  localparam int unsigned PcW   = $clog2(WIDTH + 1);
  localparam int unsigned SkipW = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
  localparam int unsigned SumW  = ((ERR_W > PcW) ? ERR_W : PcW) + 1;

  localparam logic [ERR_W-1:0] ErrMax   = '1;
  localparam logic [CYC_W-1:0] CycLast  = CYC_W'(RUN_CYCLES - 1);
  localparam logic [SkipW-1:0] SkipLast = SkipW'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam state_e           StStart  = (SKIP_CYCLES == 0) ? StCheck : StSkip;

  state_e           state_q, state_d;
  logic [SkipW-1:0] skip_q, skip_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] flag_q, flag_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [CYC_W-1:0] first_q, first_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] mis, rise;
  logic [PcW-1:0]   rise_cnt;
  logic [SumW-1:0]  err_sum;
  logic [ERR_W-1:0] err_sat;

  checker_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .vec_i   (rise),
    .count_o (rise_cnt)
  );

  always_comb begin
    mis     = bench_known & (gfpga_q ^ bench_q);
    // Only a 0->1 transition of a bit's flag counts as a new error.
    rise    = mis & ~flag_q;
    err_sum = SumW'(err_q) + SumW'(rise_cnt);
    err_sat = (err_sum > SumW'(ErrMax)) ? ErrMax : err_sum[ERR_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    cyc_d   = cyc_q;
    flag_d  = flag_q;
    err_d   = err_q;
    first_d = first_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StStart;
          skip_d  = '0;
          cyc_d   = '0;
          flag_d  = '0;
          err_d   = '0;
          first_d = '1;
        end
      end
      StSkip: begin
        if (skip_q == SkipLast) begin
          state_d = StCheck;
        end else begin
          skip_d = skip_q + SkipW'(1);
        end
      end
      StCheck: begin
        flag_d = mis;
        err_d  = err_sat;
        // err_q stays nonzero once any error is counted, so it marks "first".
        if ((rise != '0) && (err_q == '0)) begin
          first_d = cyc_q;
        end
        if (cyc_q == CycLast) begin
          state_d = StDone;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Status outputs are registered from the next state so they align with it.
    busy_d = (state_d == StSkip) || (state_d == StCheck);
    done_d = (state_d == StDone);
    pass_d = (state_d == StDone) && (err_d == '0);
  end

  always_ff @(posedge clk_counter or posedge rst_counter) begin
    if (rst_counter) begin
      state_q <= StIdle;
      skip_q  <= '0;
      cyc_q   <= '0;
      flag_q  <= '0;
      err_q   <= '0;
      first_q <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cyc_q   <= cyc_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      first_q <= first_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign mismatch_flag   = flag_q;
  assign err_count       = err_q;
  assign first_err_cycle = first_q;

endmodule

// File: doc/counter_output_checker.md
COUNTER_OUTPUT_CHECKER -- requirements
Module: counter_output_checker

Interface
REQ-001 Parameter WIDTH, default 8: number of compared output bits.
REQ-002 Parameter SKIP_CYCLES, default 1: initialisation cycles ignored after start.
REQ-003 Parameter RUN_CYCLES, default 10: compare-window length in cycles, >=1.
REQ-004 Parameter ERR_W, default 16: error-counter width.
REQ-005 Parameter CYC_W, default 16: cycle-index width.
REQ-006 clk_counter  in  1  sole clock; all state updates on rising edge.
REQ-007 rst_counter  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  single-cycle pulse that launches a check run.
REQ-009 gfpga_q  in  WIDTH  outputs of the fabric under test.
REQ-010 bench_q  in  WIDTH  outputs of the reference model.
REQ-011 bench_known  in  WIDTH  per-bit valid mask; 0 excludes the bit from comparison (unknown reference value).
REQ-012 busy  out  1  high in SKIP and CHECK.
REQ-013 done  out  1  high in DONE.
REQ-014 pass  out  1  in DONE, high iff err_count==0; 0 in all other states.
REQ-015 mismatch_flag  out  WIDTH  registered per-bit mismatch flags.
REQ-016 err_count  out  ERR_W  saturating count of flag rising events.
REQ-017 first_err_cycle  out  CYC_W  CHECK-cycle index of the first error; all-ones if there is no error.

Function
REQ-018 FSM states: IDLE, SKIP, CHECK, DONE.
REQ-019 Transitions:
- IDLE -> SKIP on start.
- SKIP -> CHECK after SKIP_CYCLES cycles in SKIP. If SKIP_CYCLES==0, start goes directly to CHECK.
- CHECK -> DONE when cyc==RUN_CYCLES-1.
- DONE -> SKIP on start.
REQ-020 start is ignored while busy=1.
REQ-021 Entry to SKIP/CHECK from start clears cyc, mismatch_flag and err_count, and sets first_err_cycle to all-ones.
REQ-022 In CHECK only: mis[i] = bench_known[i] & (gfpga_q[i] != bench_q[i]); mismatch_flag[i] <= mis[i] each cycle.
REQ-023 In CHECK, rise = mis & ~mismatch_flag; err_count increments by popcount(rise) on the same edge.
REQ-024 err_count saturates at 2^ERR_W-1 and never wraps.
REQ-025 Latency: a mismatch presented in CHECK cycle n is visible on mismatch_flag and err_count at cycle n+1.
REQ-026 A mismatch persisting across consecutive cycles counts once; it counts again only after a clean cycle.
REQ-027 first_err_cycle latches cyc on the first cycle where rise!=0; later errors do not change it.
REQ-028 mismatch_flag holds its value in SKIP, DONE and IDLE.
REQ-029 cyc increments only in CHECK and does not wrap within the run, since RUN_CYCLES <= 2^CYC_W-1.
REQ-030 Inputs are sampled only in CHECK; values in SKIP are don't-care.

Reset
REQ-031 Asserting rst_counter, including mid-run, immediately forces:
- state = IDLE
- busy = done = pass = 0
- mismatch_flag = 0, err_count = 0, cyc = 0
- first_err_cycle = all-ones
REQ-032 The first start is accepted on the first rising edge after reset deassertion.

Structure
REQ-033 Package counter_checker_pkg holds the state enum and the default values of WIDTH/ERR_W/CYC_W.
REQ-034 Sub-module checker_popcount (combinational, WIDTH-in, clog2(WIDTH+1)-out) computes popcount(rise).
REQ-035 The FSM, counters and flags stay in counter_output_checker.

Verification
REQ-036 Matching run: reset, start, gfpga_q==bench_q==8'h00..8'h09 over 10 CHECK cycles -> done=1, pass=1, err_count=0, first_err_cycle=16'hFFFF.
REQ-037 Single-bit persistent error: bit3 mismatched in CHECK cycles 2-5 -> err_count=1, first_err_cycle=2, mismatch_flag[3]=1 in cycles 3-6.
REQ-038 Multi-bit and mask: cycle 4 gfpga_q^bench_q=8'hA5 with bench_known=8'h0F -> err_count+=2 (bits 0,2), pass=0.
REQ-039 Saturation with ERR_W=2: alternate 8'hFF mismatch / clean over 10 cycles -> err_count=3.
REQ-040 Reset mid-CHECK at cycle 5 -> all outputs at reset values the same cycle; next start begins a clean run with err_count=0.
REQ-041 start pulsed during CHECK -> ignored, DONE reached at the original cycle; start in DONE restarts a run with cleared counters.
